pipelined_approx_cla_adder: RTL and testbench

Parametrised, pipelined successor to the 16-bit XNOR-based approximate carry-lookahead adder. It adds two WIDTH-bit operands over STAGES register stages using slice-wise carry-lookahead with a registered inter-slice carry. Each transaction selects exact or approximate (XNOR-sum lower bits) mode at run time. Valid/ready handshakes sit on both sides, and a saturating error monitor counts approximate results that differ from the exact sum. It sits in the approximate-arithmetic datapath, between operand producers and accuracy-characterisation or accumulation logic.

---
 rtl/pipelined_approx_cla_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_approx_cla_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_approx_cla_adder.sv
`timescale 1ns/1ps
// Pipelined slice-wise carry-lookahead adder with run-time exact/approximate (XNOR low bits) mode and error monitor.
// Latency STAGES cycles, one transaction per cycle; each slice registers its carry for the next slice.
// Backpressure: the whole pipeline holds while valid_o=1 and ready_i=0; ready_o mirrors the advance signal.
module pipelined_approx_cla_adder #(
   parameter int WIDTH       = 16,
   parameter int LOWER_WIDTH = 4,
   parameter int STAGES      = 2,
   parameter int CNT_W       = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [WIDTH-1:0]   add1_i,
   input  logic [WIDTH-1:0]   add2_i,
   input  logic               approx_en_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [WIDTH:0]     result_o,
   output logic               err_o,
   output logic [CNT_W-1:0]   err_count_o,
   input  logic               clr_err_i
);

   localparam int SW = WIDTH / STAGES;

   function automatic logic [WIDTH-1:0] lo_mask_f();
      logic [WIDTH-1:0] msk;
      msk = '0;
      for (int i = 0; i < LOWER_WIDTH; i++) msk[i] = 1'b1;
      return msk;
   endfunction

   localparam logic [WIDTH-1:0] LO_MASK = lo_mask_f();
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Returns {carry_out, sum} for one slice, every carry expanded as a full lookahead term.
   function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y,
                                             input logic          cin);
      logic [SW-1:0] g, p;
      logic [SW:0]   c;
      logic          term;
      g    = x & y;
      p    = x | y;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < SW; i++) begin
         term = cin;
         for (int j = 0; j <= i; j++) term = term & p[j];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return {c[SW], x ^ y ^ c[SW-1:0]};
   endfunction

   // cya/cye: carry of the approximate and the exact chain; dif: low slices already disagree.
   typedef struct packed {
      logic             vld;
      logic             mode;
      logic             cya;
      logic             cye;
      logic             dif;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
   } stage_t;

   stage_t st_q [STAGES];
   stage_t st_d [STAGES];
   logic   adv;

   assign adv     = ready_i | ~st_q[STAGES-1].vld;
   assign ready_o = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t        prv;
      logic [SW:0]   ra;
      logic [SW:0]   re;
      logic [SW-1:0] sum_a;

      if (k == 0) begin : g_in
         // Approximate mode injects carry-in 1 on the approximate chain only.
         always_comb begin
            prv      = '0;
            prv.vld  = valid_i;
            prv.mode = approx_en_i;
            prv.cya  = approx_en_i;
            prv.a    = add1_i;
            prv.b    = add2_i;
         end
      end else begin : g_mid
         assign prv = st_q[k-1];
      end

      assign ra    = cla_slice(prv.a[k*SW +: SW], prv.b[k*SW +: SW], prv.cya);
      assign re    = cla_slice(prv.a[k*SW +: SW], prv.b[k*SW +: SW], prv.cye);
      assign sum_a = ra[SW-1:0] ^ (prv.mode ? LO_MASK[k*SW +: SW] : '0);

      always_comb begin
         st_d[k]                  = prv;
         st_d[k].res[k*SW +: SW]  = sum_a;
         st_d[k].cya              = ra[SW];
         st_d[k].cye              = re[SW];
         st_d[k].dif              = prv.dif | (sum_a != re[SW-1:0]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
      end
   end

   assign valid_o  = st_q[STAGES-1].vld;
   assign result_o = {st_q[STAGES-1].cya, st_q[STAGES-1].res};
   assign err_o    = st_q[STAGES-1].dif | (st_q[STAGES-1].cya ^ st_q[STAGES-1].cye);

   // Clear has priority over a same-cycle increment.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_err_i) begin
         err_count_o <= '0;
      end else if (valid_o && ready_i && err_o && (err_count_o != CNT_MAX)) begin
         err_count_o <= err_count_o + CNT_W'(1);
      end
   end

   logic unused_ok;
   assign unused_ok = ^{st_q[STAGES-1].a, st_q[STAGES-1].b, st_q[STAGES-1].mode};

endmodule

// File: tb/tb_pipelined_approx_cla_adder.sv
`timescale 1ns/1ps
// Directed checks of the approximate CLA adder: default build, a 2-bit counter build and a 32-bit/4-stage build.
module tb_pipelined_approx_cla_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        v, rdy_o, m, vo, ri, err, clr;
   logic [15:0] a, b, cnt;
   logic [16:0] res;

   logic        vc, rdy_c, mc, vo_c, ri_c, err_c, clr_c;
   logic [15:0] ac, bc;
   logic [16:0] res_c;
   logic [1:0]  cnt_c;

   logic        vw, rdy_w, mw, vo_w, ri_w, err_w, clr_w;
   logic [31:0] aw, bw;
   logic [32:0] res_w;
   logic [15:0] cnt_w;

   int checks = 0;
   int errors = 0;

   pipelined_approx_cla_adder dut (
      .clk_i(clk), .rst_i(rst), .valid_i(v), .ready_o(rdy_o), .add1_i(a), .add2_i(b),
      .approx_en_i(m), .valid_o(vo), .ready_i(ri), .result_o(res), .err_o(err),
      .err_count_o(cnt), .clr_err_i(clr));

   pipelined_approx_cla_adder #(.CNT_W(2)) dut_c (
      .clk_i(clk), .rst_i(rst), .valid_i(vc), .ready_o(rdy_c), .add1_i(ac), .add2_i(bc),
      .approx_en_i(mc), .valid_o(vo_c), .ready_i(ri_c), .result_o(res_c), .err_o(err_c),
      .err_count_o(cnt_c), .clr_err_i(clr_c));

   pipelined_approx_cla_adder #(.WIDTH(32), .LOWER_WIDTH(8), .STAGES(4)) dut_w (
      .clk_i(clk), .rst_i(rst), .valid_i(vw), .ready_o(rdy_w), .add1_i(aw), .add2_i(bw),
      .approx_en_i(mw), .valid_o(vo_w), .ready_i(ri_w), .result_o(res_w), .err_o(err_w),
      .err_count_o(cnt_w), .clr_err_i(clr_w));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (vo !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", vo); end
      checks++; if (res !== 17'h0) begin errors++; $display("FAIL reset_result got=%h want=0", res); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
      checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL reset_count got=%0d want=0", cnt); end
      checks++; if (vo_w !== 1'b0) begin errors++; $display("FAIL reset_valid_w got=%b want=0", vo_w); end
      rst = 1'b0;
      step();
      checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", rdy_o); end
   endtask

   task automatic test_exact();
      ri = 1'b1; a = 16'h1234; b = 16'h4321; m = 1'b0; v = 1'b1;
      step();
      v = 1'b0;
      checks++; if (vo !== 1'b0) begin errors++; $display("FAIL exact_early_valid got=%b want=0", vo); end
      step();
      checks++; if (vo !== 1'b1) begin errors++; $display("FAIL exact_valid got=%b want=1", vo); end
      checks++; if (res !== 17'h05555) begin errors++; $display("FAIL exact_result got=%h want=05555", res); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL exact_err got=%b want=0", err); end
      step();
      checks++; if (vo !== 1'b0) begin errors++; $display("FAIL exact_single got=%b want=0", vo); end
   endtask

   task automatic test_approx();
      a = 16'h0000; b = 16'h0000; m = 1'b1; v = 1'b1;
      step(); v = 1'b0; step();
      checks++; if (res !== 17'h0000E) begin errors++; $display("FAIL approx_zero_result got=%h want=0000e", res); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL approx_zero_err got=%b want=1", err); end
      step();
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL approx_zero_count got=%0d want=1", cnt); end
      a = 16'h0003; b = 16'h0004; v = 1'b1;
      step(); v = 1'b0; step();
      checks++; if (res !== 17'h00007) begin errors++; $display("FAIL approx_3p4_result got=%h want=00007", res); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL approx_3p4_err got=%b want=0", err); end
      step();
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL approx_3p4_count got=%0d want=1", cnt); end
   endtask

   task automatic test_carry();
      a = 16'hFFFF; b = 16'h0001; m = 1'b1; v = 1'b1;
      step(); v = 1'b0; step();
      checks++; if (res !== 17'h1000E) begin errors++; $display("FAIL carry_approx_result got=%h want=1000e", res); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL carry_approx_err got=%b want=1", err); end
      m = 1'b0; v = 1'b1;
      step(); v = 1'b0; step();
      checks++; if (res !== 17'h10000) begin errors++; $display("FAIL carry_exact_result got=%h want=10000", res); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL carry_exact_err got=%b want=0", err); end
      step();
      checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL carry_count got=%0d want=2", cnt); end
   endtask

   task automatic test_back_to_back();
      int          idx = 0;
      int          got = 0;
      logic        prev_stall = 1'b0;
      logic [16:0] held = '0;
      logic [16:0] expv;
      m = 1'b0;
      for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
         ri = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         v  = (idx < 8);
         a  = 16'(idx * 32'h1111);
         b  = 16'(32'h0101 + idx);
         #1;
         checks++; if (rdy_o !== ~(vo & ~ri)) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", cyc, rdy_o, ~(vo & ~ri)); end
         if (prev_stall) begin
            checks++; if (vo !== 1'b1 || res !== held) begin errors++; $display("FAIL b2b_hold cyc=%0d got=%b/%h want=1/%h", cyc, vo, res, held); end
         end
         if (vo && ri) begin
            expv = 17'(got * 32'h1111 + 32'h0101 + got);
            checks++; if (res !== expv) begin errors++; $display("FAIL b2b_result n=%0d got=%h want=%h", got, res, expv); end
            got++;
         end
         prev_stall = vo & ~ri;
         held = res;
         if (v && rdy_o) idx++;
         step();
      end
      v = 1'b0; ri = 1'b1;
      checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", got); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (vo !== 1'b0) begin errors++; $display("FAIL b2b_extra cyc=%0d got=%b want=0", i, vo); end
      end
      checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL b2b_errcount got=%0d want=2", cnt); end
   endtask

   task automatic test_saturate();
      logic [1:0] want;
      ri_c = 1'b1; mc = 1'b1; ac = 16'h0000; bc = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         vc = 1'b1; step(); vc = 1'b0; step(); step();
         want = (i < 2) ? 2'(i + 1) : 2'd3;
         checks++; if (cnt_c !== want) begin errors++; $display("FAIL sat_count n=%0d got=%0d want=%0d", i, cnt_c, want); end
      end
      vc = 1'b1; step(); vc = 1'b0; step();
      checks++; if (vo_c !== 1'b1 || err_c !== 1'b1) begin errors++; $display("FAIL sat_clr_setup got=%b/%b want=1/1", vo_c, err_c); end
      checks++; if (rdy_c !== 1'b1) begin errors++; $display("FAIL sat_ready got=%b want=1", rdy_c); end
      clr_c = 1'b1; step(); clr_c = 1'b0;
      checks++; if (cnt_c !== 2'd0) begin errors++; $display("FAIL sat_clear got=%0d want=0", cnt_c); end
      checks++; if (res_c !== 17'h0000E) begin errors++; $display("FAIL sat_result got=%h want=0000e", res_c); end
   endtask

   task automatic test_reset_flight();
      ri = 1'b0; m = 1'b1; a = 16'h0000; b = 16'h0000; v = 1'b1;
      step();
      a = 16'h0001;
      step();
      v = 1'b0;
      checks++; if (vo !== 1'b1) begin errors++; $display("FAIL flight_setup got=%b want=1", vo); end
      rst = 1'b1; step(); rst = 1'b0;
      checks++; if (vo !== 1'b0) begin errors++; $display("FAIL flight_valid got=%b want=0", vo); end
      checks++; if (res !== 17'h0) begin errors++; $display("FAIL flight_result got=%h want=0", res); end
      checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL flight_count got=%0d want=0", cnt); end
      ri = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (vo !== 1'b0) begin errors++; $display("FAIL flight_ghost cyc=%0d got=%b want=0", i, vo); end
      end
   endtask

   task automatic test_sweep();
      logic [33:0] q[$];
      logic [33:0] e;
      logic [32:0] ex, ap;
      int          nerr = 0;
      ri_w = 1'b1;
      for (int n = 0; n < 10008; n++) begin
         checks++; if (rdy_w !== 1'b1) begin errors++; $display("FAIL sweep_ready n=%0d got=%b want=1", n, rdy_w); end
         if (vo_w) begin
            if (q.size() == 0) begin
               checks++; errors++; $display("FAIL sweep_spurious n=%0d got=%h want=none", n, res_w);
            end else begin
               e = q.pop_front();
               checks++; if ({err_w, res_w} !== e) begin errors++; $display("FAIL sweep_result n=%0d got=%b/%h want=%b/%h", n, err_w, res_w, e[33], e[32:0]); end
            end
         end
         if (n < 10000) begin
            aw = $urandom; bw = $urandom; mw = 1'($urandom_range(0, 1)); vw = 1'b1;
            ex = {1'b0, aw} + {1'b0, bw};
            ap = (ex + 33'd1) ^ 33'h0FF;
            if (mw) begin
               q.push_back({ap != ex, ap});
               if (ap != ex) nerr++;
            end else begin
               q.push_back({1'b0, ex});
            end
         end else begin
            vw = 1'b0;
         end
         step();
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL sweep_drain got=%0d want=0", q.size()); end
      checks++; if (cnt_w !== 16'((nerr > 65535) ? 65535 : nerr)) begin errors++; $display("FAIL sweep_count got=%0d want=%0d", cnt_w, nerr); end
   endtask

   initial begin
      rst = 1'b1;
      v = 1'b0; a = '0; b = '0; m = 1'b0; ri = 1'b0; clr = 1'b0;
      vc = 1'b0; ac = '0; bc = '0; mc = 1'b0; ri_c = 1'b0; clr_c = 1'b0;
      vw = 1'b0; aw = '0; bw = '0; mw = 1'b0; ri_w = 1'b0; clr_w = 1'b0;
      test_reset();
      test_exact();
      test_approx();
      test_carry();
      test_back_to_back();
      test_saturate();
      test_reset_flight();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
